// File: rtl/irr_pkg.sv
// irr_pkg: shared definitions for the irrigation scheduler.
//   state_t  - scheduler FSM states
//   err_t    - encoding of the registered err output
//   REQ_*    - per-zone two-bit request / valve codes
package irr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GAP   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_LOW   = 2'b01,
        ERR_FAULT = 2'b11
    } err_t;

    localparam logic [1:0] REQ_NONE = 2'b00;
    localparam logic [1:0] REQ_A    = 2'b01;
    localparam logic [1:0] REQ_B    = 2'b10;
    localparam logic [1:0] REQ_AB   = 2'b11;

endpackage

// File: rtl/irr_rr_arb.sv
// irr_rr_arb: combinational round-robin zone arbiter.
//   req_any     in  NZONES  one bit per zone, set when that zone requests water
//   last_idx    in  IDXW    index of the zone served most recently
//   grant_valid out 1       some zone is requesting
//   grant_idx   out IDXW    first requesting zone after last_idx, wrapping
module irr_rr_arb #(
    parameter int NZONES = 4,
    parameter int IDXW   = $clog2(NZONES)
) (
    input  logic [NZONES-1:0] req_any,
    input  logic [IDXW-1:0]   last_idx,
    output logic              grant_valid,
    output logic [IDXW-1:0]   grant_idx
);

    // Offsets 1..NZONES visit every zone once, ending on last_idx itself,
    // so a lone requester is re-granted after its own turn.
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int off = 1; off <= NZONES; off++) begin
            if (!grant_valid && req_any[(int'(last_idx) + off) % NZONES]) begin
                grant_valid = 1'b1;
                grant_idx   = IDXW'((int'(last_idx) + off) % NZONES);
            end
        end
    end

endmodule

// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: round-robin valve scheduler for NZONES zones.
//   clk          in   1         rising-edge clock
//   reset        in   1         synchronous active-high reset
//   req          in   2*NZONES  per-zone request, [2i+1:2i] = zone i
//   level_ok     in   1         supply level/pressure adequate
//   level_fault  in   1         supply fault, forces FAULT
//   fault_clr    in   1         clear latched fault (ignored while level_fault)
//   valve        out  2*NZONES  registered valve drives, layout as req
//   active_zone  out  IDXW      zone in RUN, 0 otherwise
//   busy         out  1         high in RUN or GAP
//   err          out  2         00 none, 01 supply low with requests, 11 fault
module irrigation_scheduler
    import irr_pkg::*;
#(
    parameter int NZONES     = 4,
    parameter int RUN_CYCLES = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2*NZONES-1:0]        req,
    input  logic                       level_ok,
    input  logic                       level_fault,
    input  logic                       fault_clr,
    output logic [2*NZONES-1:0]        valve,
    output logic [$clog2(NZONES)-1:0]  active_zone,
    output logic                       busy,
    output logic [1:0]                 err
);

    localparam int IDXW = $clog2(NZONES);
    localparam int MAXC = (RUN_CYCLES > GAP_CYCLES) ? RUN_CYCLES : GAP_CYCLES;
    localparam int CNTW = $clog2(MAXC + 1);
    localparam logic [CNTW-1:0] RUN_LOAD = CNTW'(RUN_CYCLES);
    localparam logic [CNTW-1:0] GAP_LOAD = CNTW'(GAP_CYCLES);

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;       // cycles left in current RUN/GAP
    logic [IDXW-1:0]   zone_q, zone_d;     // zone granted for current turn
    logic [1:0]        cap_q, cap_d;       // req value captured at grant
    logic [IDXW-1:0]   last_q, last_d;     // last-served zone

    logic [1:0]        zone_req [NZONES];
    logic [NZONES-1:0] req_any;
    logic              grant_valid;
    logic [IDXW-1:0]   grant_idx;
    logic              start_run;
    logic [2*NZONES-1:0] valve_d;
    err_t              err_d;

    always_comb begin
        for (int i = 0; i < NZONES; i++) begin
            zone_req[i] = req[2*i +: 2];
            req_any[i]  = (req[2*i +: 2] != REQ_NONE);
        end
    end

    irr_rr_arb #(
        .NZONES (NZONES),
        .IDXW   (IDXW)
    ) u_arb (
        .req_any     (req_any),
        .last_idx    (last_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Next-state logic. level_fault is tested before the state case so it
    // wins over every other event in every state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        zone_d    = zone_q;
        cap_d     = cap_q;
        last_d    = last_q;
        start_run = 1'b0;

        if (level_fault) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    start_run = level_ok && grant_valid;
                end
                ST_RUN: begin
                    // Turn ends on expiry, on the zone withdrawing its request,
                    // or on supply loss; changes between non-zero codes are
                    // ignored because the valve uses cap_q, not the live req.
                    if (cnt_q == CNTW'(1) || zone_req[zone_q] == REQ_NONE || !level_ok) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNTW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CNTW'(1)) begin
                        if (level_ok && grant_valid) begin
                            start_run = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - CNTW'(1);
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (start_run) begin
            state_d = ST_RUN;
            cnt_d   = RUN_LOAD;
            zone_d  = grant_idx;
            cap_d   = zone_req[grant_idx];
            last_d  = grant_idx;
        end
    end

    // Outputs are derived from the next state so the registered drives line
    // up with the state they describe, with no extra cycle of latency.
    always_comb begin
        valve_d = '0;
        for (int i = 0; i < NZONES; i++) begin
            if (state_d == ST_RUN && zone_d == IDXW'(i)) begin
                valve_d[2*i +: 2] = cap_d;
            end
        end

        if (state_d == ST_FAULT) begin
            err_d = ERR_FAULT;
        end else if (!level_ok && (|req_any)) begin
            err_d = ERR_LOW;
        end else begin
            err_d = ERR_NONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            zone_q      <= '0;
            cap_q       <= REQ_NONE;
            last_q      <= IDXW'(NZONES - 1);
            valve       <= '0;
            active_zone <= '0;
            busy        <= 1'b0;
            err         <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            zone_q      <= zone_d;
            cap_q       <= cap_d;
            last_q      <= last_d;
            valve       <= valve_d;
            active_zone <= (state_d == ST_RUN) ? zone_d : '0;
            busy        <= (state_d == ST_RUN) || (state_d == ST_GAP);
            err         <= err_d;
        end
    end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// tb_irrigation_scheduler: directed scenarios followed by randomized traffic,
// each cycle compared against a turn-based behavioural model.
module tb_irrigation_scheduler;

    localparam int NZ  = 4;
    localparam int RUN = 8;
    localparam int GAP = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [2*NZ-1:0] req;
    logic            level_ok;
    logic            level_fault;
    logic            fault_clr;
    logic [2*NZ-1:0] valve;
    logic [1:0]      active_zone;
    logic            busy;
    logic [1:0]      err;

    int n_checks = 0;
    int n_errors = 0;

    irrigation_scheduler #(
        .NZONES     (NZ),
        .RUN_CYCLES (RUN),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .level_ok    (level_ok),
        .level_fault (level_fault),
        .fault_clr   (fault_clr),
        .valve       (valve),
        .active_zone (active_zone),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Behavioural model: what the scheduler is doing and how many cycles of
    // the current phase have already elapsed.
    typedef enum {M_IDLE, M_WATER, M_PAUSE, M_FAULT} mode_t;
    mode_t  m_mode;
    int     m_elapsed;
    int     m_zone;
    int     m_last;
    int     m_code;
    int     m_err;

    function automatic int zone_code(input logic [2*NZ-1:0] r, input int z);
        return int'(r[2*z +: 2]);
    endfunction

    // Pick the next requesting zone after m_last; returns 1 on a grant.
    function automatic bit try_grant();
        if (!level_ok || req == '0) return 1'b0;
        for (int k = 1; k <= NZ; k++) begin
            int z;
            z = (m_last + k) % NZ;
            if (zone_code(req, z) != 0) begin
                m_mode    = M_WATER;
                m_zone    = z;
                m_code    = zone_code(req, z);
                m_last    = z;
                m_elapsed = 1;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_mode = M_IDLE; m_elapsed = 0; m_zone = 0; m_code = 0;
            m_last = NZ - 1; m_err = 0;
            return;
        end
        if (level_fault) begin
            m_mode = M_FAULT;
        end else begin
            case (m_mode)
                M_IDLE:  void'(try_grant());
                M_WATER: begin
                    if (m_elapsed == RUN || zone_code(req, m_zone) == 0 || !level_ok) begin
                        m_mode = M_PAUSE; m_elapsed = 1;
                    end else begin
                        m_elapsed++;
                    end
                end
                M_PAUSE: begin
                    if (m_elapsed == GAP) begin
                        if (!try_grant()) m_mode = M_IDLE;
                    end else begin
                        m_elapsed++;
                    end
                end
                M_FAULT: if (fault_clr) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
        end
        if (m_mode == M_FAULT)              m_err = 3;
        else if (!level_ok && req != '0)    m_err = 1;
        else                                m_err = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then
    // compare all outputs a little after the edge.
    task automatic cyc();
        int open_n;
        logic [2*NZ-1:0] exp_valve;
        @(posedge clk);
        model_step();
        #1;
        exp_valve = '0;
        if (m_mode == M_WATER) exp_valve[2*m_zone +: 2] = 2'(m_code);
        check("valve", 32'(valve), 32'(exp_valve));
        check("active_zone", 32'(active_zone), (m_mode == M_WATER) ? 32'(m_zone) : 32'd0);
        check("busy", 32'(busy), 32'(m_mode == M_WATER || m_mode == M_PAUSE));
        check("err", 32'(err), 32'(m_err));
        open_n = 0;
        for (int z = 0; z < NZ; z++) if (valve[2*z +: 2] != 2'b00) open_n++;
        check("one_zone", 32'(open_n <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        m_mode = M_IDLE; m_elapsed = 0; m_zone = 0; m_code = 0; m_last = NZ - 1; m_err = 0;
        reset = 1'b1; req = '0; level_ok = 1'b1; level_fault = 1'b0; fault_clr = 1'b0;
        #2;
        run(2);
        reset = 1'b0;

        // Single zone, valve A: 8 on, 2 off, repeat.
        req = 8'b00_00_00_01;
        run(25);

        // Zones 0,2,3 = 10,11,01: rotation 0,2,3,0.
        req = 8'b01_11_00_10;
        run(45);

        // Fault during zone 1 run, clear attempt while faulted, then clear.
        req = 8'b00_00_11_00;
        run(4);
        level_fault = 1'b1; run(1);
        fault_clr = 1'b1;   run(1);
        level_fault = 1'b0; fault_clr = 1'b0; run(3);
        fault_clr = 1'b1;   run(1);
        fault_clr = 1'b0;   run(14);

        // Supply low with zone 2 pending, then restored.
        req = 8'b00_01_00_00; level_ok = 1'b0;
        run(6);
        level_ok = 1'b1;
        run(6);

        // Zone 0 drops its request in RUN cycle 4.
        req = '0; run(12);
        req = 8'b00_00_00_01; run(4);
        req = '0; run(6);

        // Reset mid-run of zone 3, then zones 0 and 3 both request.
        req = 8'b01_00_00_00; run(4);
        reset = 1'b1; run(1);
        reset = 1'b0; req = 8'b01_00_00_01; run(24);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                int z;
                z = $urandom_range(0, NZ - 1);
                req[2*z +: 2] = 2'($urandom_range(0, 3));
            end
            if (level_ok) level_ok = ($urandom_range(0, 39) != 0);
            else          level_ok = ($urandom_range(0, 5) == 0);
            level_fault = ($urandom_range(0, 99) == 0);
            fault_clr   = ($urandom_range(0, 7) == 0);
            reset       = ($urandom_range(0, 399) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
